// File: rtl/vend_if.sv
// vend_if: vending controller bus; master drives key1/key2/cancel/change_rdy, slave drives po_thing/po_change/po_reject/po_credit/po_busy
interface vend_if #(parameter int CREDIT_W = 4);
  logic key1;
  logic key2;
  logic cancel;
  logic change_rdy;
  logic po_thing;
  logic po_change;
  logic po_reject;
  logic po_busy;
  logic [CREDIT_W-1:0] po_credit;
  modport master (
    output key1, key2, cancel, change_rdy,
    input  po_thing, po_change, po_reject, po_busy, po_credit
  );
  modport slave (
    input  key1, key2, cancel, change_rdy,
    output po_thing, po_change, po_reject, po_busy, po_credit
  );
endinterface

// File: rtl/vend_ctrl_param.sv
// vend_ctrl_param: coin-credit vending FSM; ports clk, rst (sync high), bus (vend_if.slave: keys/cancel/change_rdy in, thing/change/reject/credit/busy out)
module vend_ctrl_param #(
  parameter int CREDIT_W  = 4,
  parameter int PRICE     = 5,
  parameter int COIN1_VAL = 1,
  parameter int COIN2_VAL = 2
) (
  input logic   clk,
  input logic   rst,
  vend_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACCUM, VEND, CHANGE, REFUND} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit, credit_n, change_cnt, change_cnt_n;
  logic reject, reject_n, busy, paying;
  logic [CREDIT_W:0] coin, sum, over;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      credit     <= '0;
      change_cnt <= '0;
      reject     <= 1'b0;
    end else begin
      state      <= state_n;
      credit     <= credit_n;
      change_cnt <= change_cnt_n;
      reject     <= reject_n;
    end
  end
  always_comb begin
    busy         = state inside {VEND, CHANGE, REFUND};
    paying       = state inside {CHANGE, REFUND};
    coin         = bus.key1 ? (CREDIT_W+1)'(COIN1_VAL) : bus.key2 ? (CREDIT_W+1)'(COIN2_VAL) : '0;
    sum          = {1'b0, credit} + coin;
    over         = sum - (CREDIT_W+1)'(PRICE);
    state_n      = state;
    credit_n     = credit;
    change_cnt_n = change_cnt;
    // busy states refuse every coin; otherwise only the losing key2 of a simultaneous pair
    reject_n     = busy ? (bus.key1 | bus.key2) : (bus.key1 & bus.key2);
    case (state)
      IDLE, ACCUM: begin
        if (coin != '0) begin
          state_n      = (sum >= (CREDIT_W+1)'(PRICE)) ? VEND : ACCUM;
          credit_n     = (sum >= (CREDIT_W+1)'(PRICE)) ? '0 : sum[CREDIT_W-1:0];
          change_cnt_n = (sum >= (CREDIT_W+1)'(PRICE)) ? over[CREDIT_W-1:0] : change_cnt;
        end else if (bus.cancel && state == ACCUM) begin
          state_n      = REFUND;
          change_cnt_n = credit;
          credit_n     = '0;
        end
      end
      VEND: state_n = (change_cnt != '0) ? CHANGE : IDLE;
      CHANGE, REFUND: begin
        if (change_cnt == '0) state_n = IDLE;
        else if (bus.change_rdy) begin
          change_cnt_n = change_cnt - 1'b1;
          state_n      = (change_cnt == CREDIT_W'(1)) ? IDLE : state;
        end
      end
      default: begin
        state_n  = IDLE;
        credit_n = '0;
      end
    endcase
  end
  assign bus.po_thing  = (state == VEND);
  assign bus.po_change = paying && (change_cnt != '0);
  assign bus.po_reject = reject;
  assign bus.po_credit = credit;
  assign bus.po_busy   = busy;
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb_vend_ctrl_param: randomized and scripted checks of two vend_ctrl_param instances (default and PRICE=7/COIN2=3) against a credit/owed model
module tb_vend_ctrl_param;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;
  vend_if #(.CREDIT_W(4)) ia ();
  vend_if #(.CREDIT_W(4)) ib ();
  vend_ctrl_param dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
  vend_ctrl_param #(.CREDIT_W(4), .PRICE(7), .COIN1_VAL(1), .COIN2_VAL(3)) dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));
  int passed = 0;
  int total = 0;
  int price[2] = '{5, 7};
  int c1[2] = '{1, 1};
  int c2[2] = '{2, 3};
  int m_credit[2] = '{0, 0};
  int m_owed[2] = '{0, 0};
  bit m_vend[2] = '{0, 0};
  bit m_rej[2] = '{0, 0};
  function automatic logic [7:0] obs(int d);
    return d == 0 ? {ia.po_thing, ia.po_change, ia.po_reject, ia.po_busy, ia.po_credit}
                  : {ib.po_thing, ib.po_change, ib.po_reject, ib.po_busy, ib.po_credit};
  endfunction
  function automatic logic [7:0] expv(int d);
    return {m_vend[d], !m_vend[d] && m_owed[d] > 0, m_rej[d], m_vend[d] || m_owed[d] > 0, 4'(m_credit[d])};
  endfunction
  task automatic model_step(int d, bit rs, bit k1, bit k2, bit cn, bit rdy);
    int val, s;
    bit busy;
    busy = m_vend[d] || m_owed[d] > 0;
    if (rs) begin
      m_credit[d] = 0; m_owed[d] = 0; m_vend[d] = 0; m_rej[d] = 0;
      return;
    end
    val = k1 ? c1[d] : k2 ? c2[d] : 0;
    m_rej[d] = busy ? (k1 | k2) : (k1 & k2);
    if (m_vend[d]) m_vend[d] = 0;
    else if (m_owed[d] > 0) begin
      if (rdy) m_owed[d]--;
    end else if (val > 0) begin
      s = m_credit[d] + val;
      if (s >= price[d]) begin
        m_vend[d] = 1; m_credit[d] = 0; m_owed[d] = s - price[d];
      end else m_credit[d] = s;
    end else if (cn && m_credit[d] > 0) begin
      m_owed[d] = m_credit[d]; m_credit[d] = 0;
    end
  endtask
  task automatic tick(int d, bit rs, bit k1, bit k2, bit cn, bit rdy);
    if (d == 0) begin
      rst_a = rs; ia.key1 = k1; ia.key2 = k2; ia.cancel = cn; ia.change_rdy = rdy;
      rst_b = 0; ib.key1 = 0; ib.key2 = 0; ib.cancel = 0; ib.change_rdy = 0;
    end else begin
      rst_b = rs; ib.key1 = k1; ib.key2 = k2; ib.cancel = cn; ib.change_rdy = rdy;
      rst_a = 0; ia.key1 = 0; ia.key2 = 0; ia.cancel = 0; ia.change_rdy = 0;
    end
    @(posedge clk);
    model_step(d, rs, k1, k2, cn, rdy);
    model_step(1 - d, 0, 0, 0, 0, 0);
    #1;
  endtask
  task automatic test_reset();
    tick(0, 1, 1, 1, 1, 1);
    tick(1, 1, 1, 1, 1, 1);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (obs(d) !== 8'h00 || expv(d) !== 8'h00) $display("FAIL reset dut%0d: got %h want 00", d, obs(d));
      else passed++;
    end
  endtask
  task automatic test_exact();
    logic [2:0] s[10];
    int things = 0, units = 0;
    s = '{3'b100, 0, 3'b100, 0, 3'b010, 0, 3'b100, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      units += int'(ia.po_change);
      tick(0, 0, s[i][2], s[i][1], s[i][0], 1);
      things += int'(ia.po_thing);
      total++;
      if (obs(0) !== expv(0)) $display("FAIL exact cyc%0d: got %h want %h", i, obs(0), expv(0));
      else passed++;
    end
    total++;
    if (things !== 1 || units !== 0) $display("FAIL exact_counts: got thing=%0d change=%0d want 1/0", things, units);
    else passed++;
  endtask
  task automatic test_change();
    logic [2:0] s[9];
    int units = 0;
    s = '{3'b010, 0, 3'b010, 0, 3'b010, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      units += int'(ia.po_change);
      tick(0, 0, s[i][2], s[i][1], s[i][0], 1);
      total++;
      if (obs(0) !== expv(0)) $display("FAIL change cyc%0d: got %h want %h", i, obs(0), expv(0));
      else passed++;
    end
    total++;
    if (units !== 1) $display("FAIL change_units: got %0d want 1", units);
    else passed++;
  endtask
  task automatic test_refund_stall();
    logic [2:0] s[5];
    int units = 0, things = 0;
    s = '{3'b010, 0, 3'b100, 0, 3'b001};
    for (int i = 0; i < 16; i++) begin
      bit r;
      r = i >= 10;
      units += int'(ia.po_change && r);
      if (i < 5) tick(0, 0, s[i][2], s[i][1], s[i][0], r);
      else tick(0, 0, 0, 0, 0, r);
      things += int'(ia.po_thing);
      total++;
      if (obs(0) !== expv(0)) $display("FAIL refund cyc%0d: got %h want %h", i, obs(0), expv(0));
      else passed++;
    end
    total++;
    if (units !== 3 || things !== 0) $display("FAIL refund_counts: got units=%0d thing=%0d want 3/0", units, things);
    else passed++;
  endtask
  task automatic test_reject();
    logic [3:0] s[14];
    s = '{4'b1101, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0100, 0, 4'b0100, 0, 4'b0100,
          0, 4'b0100, 4'b0001, 4'b0001};
    for (int i = 0; i < 14; i++) begin
      tick(0, 0, s[i][3], s[i][2], s[i][1], s[i][0]);
      total++;
      if (obs(0) !== expv(0)) $display("FAIL reject cyc%0d: got %h want %h", i, obs(0), expv(0));
      else passed++;
    end
  endtask
  task automatic test_reset_mid();
    logic [2:0] s[7];
    int units = 0;
    s = '{3'b010, 0, 3'b010, 0, 3'b010, 0, 0};
    for (int i = 0; i < 7; i++) tick(1, 0, s[i][2], s[i][1], s[i][0], 0);
    total++;
    if (ib.po_change !== 1'b1 || m_owed[1] !== 2) $display("FAIL mid_pre: got change=%b want 1 with 2 owed", ib.po_change);
    else passed++;
    tick(1, 1, 0, 0, 0, 1);
    total++;
    if (obs(1) !== 8'h00) $display("FAIL mid_rst: got %h want 00", obs(1));
    else passed++;
    for (int i = 0; i < 4; i++) begin
      units += int'(ib.po_change);
      tick(1, 0, 0, 0, 0, 1);
    end
    total++;
    if (units !== 0 || obs(1) !== expv(1)) $display("FAIL mid_after: got units=%0d out=%h want 0/%h", units, obs(1), expv(1));
    else passed++;
  endtask
  task automatic test_override();
    logic [2:0] s[6];
    int units = 0, things = 0;
    s = '{3'b010, 0, 3'b010, 0, 3'b010, 0};
    for (int i = 0; i < 11; i++) begin
      units += int'(ib.po_change);
      if (i < 6) tick(1, 0, s[i][2], s[i][1], s[i][0], 1);
      else tick(1, 0, 0, 0, 0, 1);
      things += int'(ib.po_thing);
      total++;
      if (obs(1) !== expv(1)) $display("FAIL override cyc%0d: got %h want %h", i, obs(1), expv(1));
      else passed++;
    end
    total++;
    if (units !== 2 || things !== 1) $display("FAIL override_counts: got units=%0d thing=%0d want 2/1", units, things);
    else passed++;
  endtask
  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      int d;
      d = i < 2000 ? 0 : 1;
      tick(d, $urandom_range(199) == 0, $urandom_range(4) == 0, $urandom_range(3) == 0,
           $urandom_range(5) == 0, $urandom_range(2) != 0);
      total++;
      if (obs(d) !== expv(d)) $display("FAIL random dut%0d cyc%0d: got %h want %h", d, i, obs(d), expv(d));
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_exact();
    test_change();
    test_refund_stall();
    test_reject();
    test_reset_mid();
    test_override();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
